ahb2apb_bridge_param: RTL and testbench
=======================================

# ahb2apb_bridge_param

Parametrised second-generation AHB-to-APB bridge: accepts single AHB-Lite transfers and replays them as APB3 transfers to one of NUM_SLV decoded slaves. Adds APB wait states (Pready), slave error (Pslverr), out-of-range decode error and an access timeout, none of which the first-generation Bridge_Top supports. Drop-in replacement for Bridge_Top at the AHB/APB boundary.

## Interface
- DATA_W, 32, AHB/APB data width (8, 16 or 32)
- ADDR_W, 32, address width
- NUM_SLV, 3, number of APB slaves (1..8); width of Pselx
- BASE, 32'h8000_0000, start of slave 0 region
- REGION_SHIFT, 26, log2 of region size (64 MiB)
- TIMEOUT, 16, max ACCESS cycles without Pready before abort (≥2)

- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous reset, active-high
- Hwrite  in  1  1=write, 0=read
- Hreadyin  in  1  AHB HREADY from interconnect
- Htrans  in  2  transfer type; bit 1 set = NONSEQ/SEQ (valid)
- Haddr  in  ADDR_W  address-phase address
- Hwdata  in  DATA_W  write data, valid in the data phase
- Prdata  in  DATA_W  APB read data
- Pready  in  1  APB slave ready
- Pslverr  in  1  APB slave error, sampled with Pready
- Pselx  out  NUM_SLV  one-hot slave select
- Paddr  out  ADDR_W  APB address
- Pwdata  out  DATA_W  APB write data
- Pwrite  out  1  APB direction
- Penable  out  1  APB access phase
- Hreadyout  out  1  bridge ready to AHB
- Hresp  out  2  00 OKAY, 01 ERROR
- Hrdata  out  DATA_W  read data to AHB

## Operation
- Accept: Htrans[1] && Hreadyin && Hreadyout at a rising edge; Haddr, Hwrite and the decoded slave index are registered. All other cycles are ignored (IDLE/BUSY → OKAY, Hreadyout stays 1).
- Decode: slave i hit iff BASE + i·2^REGION_SHIFT ≤ Haddr < BASE + (i+1)·2^REGION_SHIFT, i < NUM_SLV. No hit → decode error; no APB cycle is issued.
- States: IDLE, WWAIT, SETUP, ACCESS, ERR1, ERR2, DONE.
  - IDLE: on read accept → SETUP; on write accept → WWAIT; on miss → ERR1.
  - WWAIT: Hwdata registered into Pwdata → SETUP.
  - SETUP: Pselx[idx]=1, Penable=0 → ACCESS.
  - ACCESS: Penable=1; Pready && !Pslverr → DONE (read: Hrdata←Prdata); Pready && Pslverr → ERR1; counter reaching TIMEOUT with Pready=0 → ERR1.
  - ERR1: Hreadyout=0, Hresp=01 → ERR2. ERR2: Hreadyout=1, Hresp=01 → IDLE.
  - DONE: Hreadyout=1, Hresp=00, behaves as IDLE for accept (back-to-back allowed).
- Pselx/Penable deassert on the edge leaving ACCESS. Paddr/Pwrite/Pwdata hold their last value when no transfer is in progress.
- Timeout counter: clears on SETUP entry, increments each ACCESS cycle; $clog2(TIMEOUT+1) bits; never wraps.
- Hrdata updates only on a successful read completion; otherwise it holds.

## Timing
- Reset values: Pselx=0, Penable=0, Pwrite=0, Paddr=0, Pwdata=0, Hrdata=0, Hreadyout=1, Hresp=00; state=IDLE; counter=0.
- rst asserted in any state, including mid-ACCESS: every output takes its reset value on that edge. No APB completion is reported.
- Read, zero wait (accept at T0): T1 SETUP, T2 ACCESS, T3 Hreadyout=1 with valid Hrdata. Hreadyout=0 during T1–T2.
- Write, zero wait: T1 WWAIT, T2 SETUP, T3 ACCESS, T4 Hreadyout=1.
- Each Pready=0 cycle in ACCESS adds one cycle. Paddr, Pwrite, Pwdata and Pselx are stable from SETUP through the end of ACCESS.
- Error response: exactly 2 cycles with Hresp=01, Hreadyout 0 then 1. The next transfer may be accepted on the ERR2 cycle's edge only if Htrans is valid; otherwise the bridge returns to IDLE.
- Accept in DONE/ERR2 follows the same latencies, counted from that edge.

## Test plan
- Reset mid-ACCESS: read 0x8400_0010, hold Pready=0, assert rst at ACCESS cycle 2 → next cycle Pselx=000, Penable=0, Hreadyout=1, Hresp=00.
- Zero-wait write: write 0x8800_0004 with data 0xDEAD_BEEF → Pselx=100 and Pwdata=0xDEAD_BEEF at T2–T3, Penable=1 at T3, Hreadyout=1 at T4.
- Wait-state read: read 0x8000_0000, Pready low for 3 cycles, Prdata=0x1234_5678 → ACCESS lasts 4 cycles and Hrdata=0x1234_5678 with Hreadyout=1 the following cycle.
- Slave error: write with Pready=1, Pslverr=1 → Hresp=01 for 2 cycles (Hreadyout 0 then 1), then OKAY.
- Decode miss and timeout: read 0x8C00_0000 → no Pselx and a 2-cycle ERROR. Read 0x8000_0000 with Pready=0 held → abort after 16 ACCESS cycles with a 2-cycle ERROR.
- Back-to-back plus NUM_SLV=8 build: write then read, with the read accepted on the DONE cycle → second SETUP occurs at DONE+1. Address BASE+7·2^26 → Pselx=1000_0000.

Source files
------------

// File: rtl/ahb2apb_bridge_param.sv
// ahb2apb_bridge_param: parametrised AHB-Lite to APB3 bridge.
// Single-transfer replay with APB wait states, slave error, decode error and access timeout.
module ahb2apb_bridge_param #(
    parameter int unsigned       DATA_W       = 32,
    parameter int unsigned       ADDR_W       = 32,
    parameter int unsigned       NUM_SLV      = 3,
    parameter logic [ADDR_W-1:0] BASE         = ADDR_W'(32'h8000_0000),
    parameter int unsigned       REGION_SHIFT = 26,
    parameter int unsigned       TIMEOUT      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Hwrite,
    input  logic              Hreadyin,
    input  logic [1:0]        Htrans,
    input  logic [ADDR_W-1:0] Haddr,
    input  logic [DATA_W-1:0] Hwdata,
    input  logic [DATA_W-1:0] Prdata,
    input  logic              Pready,
    input  logic              Pslverr,
    output logic [NUM_SLV-1:0] Pselx,
    output logic [ADDR_W-1:0] Paddr,
    output logic [DATA_W-1:0] Pwdata,
    output logic              Pwrite,
    output logic              Penable,
    output logic              Hreadyout,
    output logic [1:0]        Hresp,
    output logic [DATA_W-1:0] Hrdata
);

    localparam int unsigned IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [1:0]  RESP_OKAY = 2'b00;
    localparam logic [1:0]  RESP_ERR  = 2'b01;

    typedef enum logic [2:0] {
        IDLE, WWAIT, SETUP, ACCESS, ERR1, ERR2, DONE
    } state_t;

    state_t            state;
    logic [IDX_W-1:0]  idx_q;
    logic [CNT_W-1:0]  cnt;

    logic [ADDR_W-1:0] offset;
    logic [ADDR_W-1:0] region;
    logic              hit;
    logic [IDX_W-1:0]  dec_idx;
    logic              accept;

    // Htrans[0] only distinguishes NONSEQ from SEQ, which the bridge treats alike
    logic unused_htrans0;
    assign unused_htrans0 = Htrans[0];

    // Address decode: region index relative to BASE, hit only inside the slave window
    always_comb begin
        offset  = Haddr - BASE;
        region  = offset >> REGION_SHIFT;
        hit     = (Haddr >= BASE) && (region < ADDR_W'(NUM_SLV));
        dec_idx = IDX_W'(region);
        accept  = Htrans[1] && Hreadyin && Hreadyout;
    end

    function automatic logic [NUM_SLV-1:0] onehot(input logic [IDX_W-1:0] idx);
        return NUM_SLV'(1) << idx;
    endfunction

    // Bridge FSM with registered APB and AHB response outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx_q     <= '0;
            cnt       <= '0;
            Pselx     <= '0;
            Paddr     <= '0;
            Pwdata    <= '0;
            Pwrite    <= 1'b0;
            Penable   <= 1'b0;
            Hreadyout <= 1'b1;
            Hresp     <= RESP_OKAY;
            Hrdata    <= '0;
        end else begin
            case (state)
                IDLE, DONE, ERR2: begin
                    Hreadyout <= 1'b1;
                    Hresp     <= RESP_OKAY;
                    state     <= IDLE;
                    if (accept) begin
                        Hreadyout <= 1'b0;
                        if (!hit) begin
                            Hresp <= RESP_ERR;
                            state <= ERR1;
                        end else begin
                            idx_q  <= dec_idx;
                            Paddr  <= Haddr;
                            Pwrite <= Hwrite;
                            if (Hwrite) begin
                                state <= WWAIT;
                            end else begin
                                Pselx <= onehot(dec_idx);
                                cnt   <= '0;
                                state <= SETUP;
                            end
                        end
                    end
                end
                WWAIT: begin
                    Pwdata <= Hwdata;
                    Pselx  <= onehot(idx_q);
                    cnt    <= '0;
                    state  <= SETUP;
                end
                SETUP: begin
                    Penable <= 1'b1;
                    cnt     <= CNT_W'(1);
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (Pready) begin
                        Pselx   <= '0;
                        Penable <= 1'b0;
                        if (Pslverr) begin
                            Hresp <= RESP_ERR;
                            state <= ERR1;
                        end else begin
                            Hreadyout <= 1'b1;
                            if (!Pwrite) begin
                                Hrdata <= Prdata;
                            end
                            state <= DONE;
                        end
                    end else if (cnt == CNT_W'(TIMEOUT)) begin
                        Pselx   <= '0;
                        Penable <= 1'b0;
                        Hresp   <= RESP_ERR;
                        state   <= ERR1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ERR1: begin
                    Hreadyout <= 1'b1;
                    Hresp     <= RESP_ERR;
                    state     <= ERR2;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb2apb_bridge_param.sv
// Directed bench for ahb2apb_bridge_param: default build plus an 8-slave build.
module tb_ahb2apb_bridge_param;

    logic        clk;
    logic        rst;
    logic        hwrite;
    logic        hreadyin;
    logic [1:0]  htrans;
    logic [1:0]  htrans8;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    logic [2:0]  pselx;
    logic [31:0] paddr, pwdata, hrdata;
    logic        pwrite, penable, hreadyout;
    logic [1:0]  hresp;

    logic [7:0]  pselx8;
    logic [31:0] paddr8, pwdata8, hrdata8;
    logic        pwrite8, penable8, hreadyout8;
    logic [1:0]  hresp8;

    int total = 0;
    int bad   = 0;

    ahb2apb_bridge_param u_dut (
        .clk(clk), .rst(rst), .Hwrite(hwrite), .Hreadyin(hreadyin), .Htrans(htrans),
        .Haddr(haddr), .Hwdata(hwdata), .Prdata(prdata), .Pready(pready), .Pslverr(pslverr),
        .Pselx(pselx), .Paddr(paddr), .Pwdata(pwdata), .Pwrite(pwrite), .Penable(penable),
        .Hreadyout(hreadyout), .Hresp(hresp), .Hrdata(hrdata)
    );

    ahb2apb_bridge_param #(.NUM_SLV(8)) u_dut8 (
        .clk(clk), .rst(rst), .Hwrite(hwrite), .Hreadyin(hreadyin), .Htrans(htrans8),
        .Haddr(haddr), .Hwdata(hwdata), .Prdata(prdata), .Pready(pready), .Pslverr(pslverr),
        .Pselx(pselx8), .Paddr(paddr8), .Pwdata(pwdata8), .Pwrite(pwrite8), .Penable(penable8),
        .Hreadyout(hreadyout8), .Hresp(hresp8), .Hrdata(hrdata8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; hwrite = 1'b0; hreadyin = 1'b1; htrans = 2'b00; htrans8 = 2'b00;
        haddr = '0; hwdata = '0; prdata = '0; pready = 1'b0; pslverr = 1'b0;
        tick();
        tick();
        chk("rst_pselx", 32'(pselx), 32'h0);
        chk("rst_penable", 32'(penable), 32'h0);
        chk("rst_hreadyout", 32'(hreadyout), 32'h1);
        chk("rst_hresp", 32'(hresp), 32'h0);
        chk("rst_paddr", paddr, 32'h0);
        chk("rst_pwdata", pwdata, 32'h0);
        chk("rst_pwrite", 32'(pwrite), 32'h0);
        chk("rst_hrdata", hrdata, 32'h0);

        // Reset in the middle of a stalled ACCESS
        rst = 1'b0;
        htrans = 2'b10; hwrite = 1'b0; haddr = 32'h8400_0010; pready = 1'b0;
        tick();
        chk("r1_setup_pselx", 32'(pselx), 32'h2);
        chk("r1_setup_penable", 32'(penable), 32'h0);
        chk("r1_setup_hready", 32'(hreadyout), 32'h0);
        chk("r1_setup_paddr", paddr, 32'h8400_0010);
        htrans = 2'b00;
        tick();
        chk("r1_access1_penable", 32'(penable), 32'h1);
        tick();
        chk("r1_access2_penable", 32'(penable), 32'h1);
        rst = 1'b1;
        tick();
        chk("r1_after_rst_pselx", 32'(pselx), 32'h0);
        chk("r1_after_rst_penable", 32'(penable), 32'h0);
        chk("r1_after_rst_hready", 32'(hreadyout), 32'h1);
        chk("r1_after_rst_hresp", 32'(hresp), 32'h0);
        rst = 1'b0;
        tick();

        // Zero-wait write to slave 2
        pready = 1'b1;
        htrans = 2'b10; hwrite = 1'b1; haddr = 32'h8800_0004;
        tick();
        chk("w_t1_hready", 32'(hreadyout), 32'h0);
        chk("w_t1_pselx", 32'(pselx), 32'h0);
        hwdata = 32'hDEAD_BEEF; htrans = 2'b00;
        tick();
        chk("w_t2_pselx", 32'(pselx), 32'h4);
        chk("w_t2_pwdata", pwdata, 32'hDEAD_BEEF);
        chk("w_t2_penable", 32'(penable), 32'h0);
        chk("w_t2_paddr", paddr, 32'h8800_0004);
        chk("w_t2_pwrite", 32'(pwrite), 32'h1);
        tick();
        chk("w_t3_pselx", 32'(pselx), 32'h4);
        chk("w_t3_penable", 32'(penable), 32'h1);
        chk("w_t3_pwdata", pwdata, 32'hDEAD_BEEF);
        chk("w_t3_hready", 32'(hreadyout), 32'h0);
        tick();
        chk("w_t4_hready", 32'(hreadyout), 32'h1);
        chk("w_t4_hresp", 32'(hresp), 32'h0);
        chk("w_t4_pselx", 32'(pselx), 32'h0);
        chk("w_t4_penable", 32'(penable), 32'h0);
        chk("w_t4_pwdata_hold", pwdata, 32'hDEAD_BEEF);

        // Read with three wait states, accepted on the DONE cycle
        pready = 1'b0; prdata = 32'h1234_5678;
        htrans = 2'b10; hwrite = 1'b0; haddr = 32'h8000_0000;
        tick();
        chk("rw_setup_pselx", 32'(pselx), 32'h1);
        chk("rw_setup_penable", 32'(penable), 32'h0);
        htrans = 2'b00;
        tick();
        chk("rw_acc1", 32'(penable), 32'h1);
        tick();
        chk("rw_acc2", 32'(penable), 32'h1);
        tick();
        chk("rw_acc3", 32'(penable), 32'h1);
        chk("rw_acc3_hready", 32'(hreadyout), 32'h0);
        tick();
        chk("rw_acc4", 32'(penable), 32'h1);
        chk("rw_acc4_hrdata_hold", hrdata, 32'h0);
        pready = 1'b1;
        tick();
        chk("rw_done_hrdata", hrdata, 32'h1234_5678);
        chk("rw_done_hready", 32'(hreadyout), 32'h1);
        chk("rw_done_penable", 32'(penable), 32'h0);

        // Slave error on a write
        pslverr = 1'b1;
        htrans = 2'b10; hwrite = 1'b1; haddr = 32'h8000_0100;
        tick();
        hwdata = 32'h0000_A5A5; htrans = 2'b00;
        tick();
        chk("se_setup_pselx", 32'(pselx), 32'h1);
        tick();
        chk("se_access_penable", 32'(penable), 32'h1);
        tick();
        chk("se_err1_hresp", 32'(hresp), 32'h1);
        chk("se_err1_hready", 32'(hreadyout), 32'h0);
        chk("se_err1_pselx", 32'(pselx), 32'h0);
        tick();
        chk("se_err2_hresp", 32'(hresp), 32'h1);
        chk("se_err2_hready", 32'(hreadyout), 32'h1);
        tick();
        chk("se_idle_hresp", 32'(hresp), 32'h0);
        chk("se_idle_hready", 32'(hreadyout), 32'h1);
        pslverr = 1'b0;

        // Decode miss: one region past the last slave
        htrans = 2'b10; hwrite = 1'b0; haddr = 32'h8C00_0000;
        tick();
        chk("dm_err1_pselx", 32'(pselx), 32'h0);
        chk("dm_err1_hresp", 32'(hresp), 32'h1);
        chk("dm_err1_hready", 32'(hreadyout), 32'h0);
        htrans = 2'b00;
        tick();
        chk("dm_err2_hresp", 32'(hresp), 32'h1);
        chk("dm_err2_hready", 32'(hreadyout), 32'h1);
        chk("dm_err2_pselx", 32'(pselx), 32'h0);
        tick();
        chk("dm_idle_hresp", 32'(hresp), 32'h0);
        chk("dm_paddr_hold", paddr, 32'h8000_0100);

        // Timeout: Pready never rises
        pready = 1'b0; prdata = 32'hFFFF_0000;
        htrans = 2'b10; hwrite = 1'b0; haddr = 32'h8000_0000;
        tick();
        htrans = 2'b00;
        for (int i = 1; i <= 16; i++) begin
            tick();
            chk($sformatf("to_access%0d", i), 32'(penable), 32'h1);
        end
        tick();
        chk("to_err1_hresp", 32'(hresp), 32'h1);
        chk("to_err1_hready", 32'(hreadyout), 32'h0);
        chk("to_err1_penable", 32'(penable), 32'h0);
        chk("to_err1_pselx", 32'(pselx), 32'h0);
        tick();
        chk("to_err2_hresp", 32'(hresp), 32'h1);
        chk("to_err2_hready", 32'(hreadyout), 32'h1);
        tick();
        chk("to_idle_hresp", 32'(hresp), 32'h0);
        chk("to_hrdata_hold", hrdata, 32'h1234_5678);

        // BUSY transfer is ignored
        htrans = 2'b01;
        tick();
        chk("busy_hready", 32'(hreadyout), 32'h1);
        chk("busy_pselx", 32'(pselx), 32'h0);
        htrans = 2'b00;

        // 8-slave build: back-to-back write then read to the top slave
        pready = 1'b1;
        htrans8 = 2'b10; hwrite = 1'b1; haddr = 32'h9C00_0000;
        tick();
        chk("b2b_wwait_hready", 32'(hreadyout8), 32'h0);
        hwdata = 32'hCAFE_F00D; htrans8 = 2'b00;
        tick();
        chk("b2b_w_setup_pselx", 32'(pselx8), 32'h80);
        chk("b2b_w_setup_pwdata", pwdata8, 32'hCAFE_F00D);
        tick();
        chk("b2b_w_access_penable", 32'(penable8), 32'h1);
        tick();
        chk("b2b_w_done_hready", 32'(hreadyout8), 32'h1);
        chk("b2b_w_done_hresp", 32'(hresp8), 32'h0);
        htrans8 = 2'b10; hwrite = 1'b0; haddr = 32'h9C00_0040; prdata = 32'h0BAD_CAFE;
        tick();
        chk("b2b_r_setup_pselx", 32'(pselx8), 32'h80);
        chk("b2b_r_setup_penable", 32'(penable8), 32'h0);
        chk("b2b_r_setup_hready", 32'(hreadyout8), 32'h0);
        chk("b2b_r_setup_paddr", paddr8, 32'h9C00_0040);
        chk("b2b_r_setup_pwrite", 32'(pwrite8), 32'h0);
        htrans8 = 2'b00;
        tick();
        chk("b2b_r_access_penable", 32'(penable8), 32'h1);
        tick();
        chk("b2b_r_done_hrdata", hrdata8, 32'h0BAD_CAFE);
        chk("b2b_r_done_hready", 32'(hreadyout8), 32'h1);
        chk("main_idle_pselx", 32'(pselx), 32'h0);
        chk("main_hrdata_hold", hrdata, 32'h1234_5678);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
